// File: rtl/half_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : half_link_arbiter
// Description : Round-robin packet arbiter that shares one 32-bit half-rate
//               link between NUM_SRC valid/ready word streams. Every burst is
//               prefixed by a header word (sync byte, source id, continuation
//               flag, per-source sequence number). Each grant is limited to
//               MAX_BURST payload words so that no source can hog the link.
// Revision    : 1.0 - initial release
// ============================================================================
module half_link_arbiter #(
  parameter int         NUM_SRC   = 4,
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC*32-1:0]  t_data,
  input  logic [NUM_SRC-1:0]     t_valid,
  input  logic [NUM_SRC-1:0]     t_last,
  output logic [NUM_SRC-1:0]     t_ready,
  output logic [31:0]            i0_data,
  output logic                   i0_valid,
  input  logic                   i0_ready,
  output logic [3:0]             grant_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Index of the final payload word allowed in one grant.
  localparam logic [7:0] C_LAST_WORD_IDX = 8'(MAX_BURST - 1);
  // Arbitration pointer reset value, so that source 0 is scanned first.
  localparam logic [3:0] C_LAST_GRANT_RST = 4'(NUM_SRC - 1);

  state_t       state_q, state_d;
  logic [3:0]   grant_q, grant_d;
  logic [3:0]   last_grant_q, last_grant_d;
  logic [7:0]   word_cnt_q, word_cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_data_q, out_data_d;
  logic [7:0]   seq_q [NUM_SRC];
  logic [NUM_SRC-1:0] cont_q;

  logic         out_free;
  logic         seq_inc;
  logic         cont_wr;
  logic         cont_val;

  logic [31:0]  src_data [NUM_SRC];
  logic [31:0]  sel_data;
  logic         sel_valid;
  logic         sel_last;
  logic [7:0]   sel_seq;
  logic         sel_cont;

  logic         arb_found;
  logic [3:0]   arb_idx;

  // The output register can take a new word when empty or being drained now.
  assign out_free = !out_valid_q || i0_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_unpack
      assign src_data[g] = t_data[32*g +: 32];
    end
  endgenerate

  // Select the payload, handshake and per-source state of the granted source.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_seq   = '0;
    sel_cont  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 4'(i)) begin
        sel_data  = src_data[i];
        sel_valid = t_valid[i];
        sel_last  = t_last[i];
        sel_seq   = seq_q[i];
        sel_cont  = cont_q[i];
      end
    end
  end

  // Round-robin pick: first requester above the last grant, else lowest one.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!arb_found && t_valid[j] && (4'(j) > last_grant_q)) begin
        arb_found = 1'b1;
        arb_idx   = 4'(j);
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!arb_found && t_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = 4'(j);
      end
    end
  end

  // Next-state, output-register and per-source bookkeeping decisions.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    seq_inc      = 1'b0;
    cont_wr      = 1'b0;
    cont_val     = 1'b0;
    t_ready      = '0;

    // A word that is consumed (or an empty slot) leaves the register empty
    // unless something below reloads it in the same cycle.
    if (out_free) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // The last burst word may still be pending; the header simply waits.
        if (arb_found) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ST_HDR;
        end
      end

      ST_HDR: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = {SYNC_BYTE, 4'h0, grant_q, sel_cont, 7'h0, sel_seq};
          seq_inc     = 1'b1;
          word_cnt_d  = '0;
          state_d     = ST_BURST;
        end
      end

      ST_BURST: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          t_ready[i] = (grant_q == 4'(i)) && out_free;
        end
        // A stalled source keeps the grant; the link just sees a bubble.
        if (sel_valid && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          word_cnt_d  = word_cnt_q + 8'd1;
          if (sel_last) begin
            cont_wr  = 1'b1;
            cont_val = 1'b0;
            state_d  = ST_IDLE;
          end else if (word_cnt_q == C_LAST_WORD_IDX) begin
            cont_wr  = 1'b1;
            cont_val = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, grant pointers and the link output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= C_LAST_GRANT_RST;
      word_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Per-source sequence numbers and continuation flags of the granted source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        seq_q[i] <= '0;
      end
      cont_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == 4'(i)) begin
          if (seq_inc) begin
            seq_q[i] <= seq_q[i] + 8'd1;
          end
          if (cont_wr) begin
            cont_q[i] <= cont_val;
          end
        end
      end
    end
  end

  assign i0_valid = out_valid_q;
  assign i0_data  = out_data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_half_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_link_arbiter
// Description : Directed self-checking bench for half_link_arbiter. Source
//               packets are queued per source, link words are collected and
//               compared against hand-built expected word lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_link_arbiter;

  localparam int NSRC = 4;
  localparam int MAXB = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NSRC*32-1:0]   t_data;
  logic [NSRC-1:0]      t_valid;
  logic [NSRC-1:0]      t_last;
  logic [NSRC-1:0]      t_ready;
  logic [31:0]          i0_data;
  logic                 i0_valid;
  logic                 i0_ready;
  logic [3:0]           grant_id;
  logic                 busy;

  half_link_arbiter #(
    .NUM_SRC   (NSRC),
    .MAX_BURST (MAXB),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .t_data   (t_data),
    .t_valid  (t_valid),
    .t_last   (t_last),
    .t_ready  (t_ready),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_ready (i0_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stab_err = 0;
  int          onehot_err = 0;
  logic [31:0] sq_d [NSRC][$];
  bit          sq_l [NSRC][$];
  bit          pres [NSRC];
  logic [31:0] obs [$];
  int          obs_t [$];
  logic [31:0] exp_q [$];
  bit          rnd_ready = 1'b0;
  bit          gap_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int          start_cyc;
  int          n_words;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] dw(input int s, input int p, input int i);
    return {4'(s), 12'(p), 16'(i)};
  endfunction

  function automatic logic [31:0] hw(input int s, input int c, input int q);
    return {8'hA5, 4'h0, 4'(s), 1'(c), 7'h0, 8'(q)};
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (sq_d[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic drive();
    for (int k = 0; k < NSRC; k++) begin
      if (!pres[k] && sq_d[k].size() > 0) begin
        pres[k] = gap_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      t_valid[k]          = pres[k];
      t_data[32*k +: 32]  = pres[k] ? sq_d[k][0] : 32'h0;
      t_last[k]           = pres[k] ? sq_l[k][0] : 1'b0;
    end
    i0_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic step();
    bit hs [NSRC];
    @(negedge clk);
    cyc++;
    if ($countones(t_ready) > 1) onehot_err++;
    if ((t_ready != '0) && !busy) onehot_err++;
    if (prev_stall && (!i0_valid || (i0_data !== prev_data))) stab_err++;
    prev_stall = i0_valid && !i0_ready;
    prev_data  = i0_data;
    if (i0_valid && i0_ready) begin
      obs.push_back(i0_data);
      obs_t.push_back(cyc);
    end
    for (int k = 0; k < NSRC; k++) hs[k] = t_valid[k] && t_ready[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < NSRC; k++) begin
      if (hs[k]) begin
        void'(sq_d[k].pop_front());
        void'(sq_l[k].pop_front());
        pres[k] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic clear_all();
    for (int k = 0; k < NSRC; k++) begin
      sq_d[k].delete();
      sq_l[k].delete();
      pres[k] = 1'b0;
    end
    obs.delete();
    obs_t.delete();
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic add_pkt(input int s, input int p, input int len);
    for (int i = 0; i < len; i++) begin
      sq_d[s].push_back(dw(s, p, i));
      sq_l[s].push_back(i == len - 1);
    end
  endtask

  task automatic exp_words(input int s, input int p, input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back(dw(s, p, i));
  endtask

  task automatic run_until(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = all_empty() && (obs.size() >= exp_q.size()) && !busy && !i0_valid;
    end
    chk({tag, " completion"}, 32'(done), 32'd1);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " word count"}, 32'(obs.size()), 32'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s word %0d", tag, i), obs[i], exp_q[i]);
    end
    obs.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    t_data   = '0;
    t_valid  = '0;
    t_last   = '0;
    i0_ready = 1'b1;
    for (int k = 0; k < NSRC; k++) pres[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset i0_valid", 32'(i0_valid), 32'd0);
    chk("reset i0_data", i0_data, 32'd0);
    chk("reset t_ready", 32'(t_ready), 32'd0);
    chk("reset grant_id", 32'(grant_id), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Idle link with no requests.
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle i0_valid", 32'(i0_valid), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle t_ready", 32'(t_ready), 32'd0);
    end

    // Single source, 3-word packet then 1-word packet.
    start_cyc = cyc;
    add_pkt(2, 0, 3);
    drive();
    exp_q.push_back(hw(2, 0, 0));
    exp_words(2, 0, 0, 2);
    run_until("src2 pkt0", 50);
    chk("src2 words seen", 32'(obs_t.size() >= 4), 32'd1);
    if (obs_t.size() >= 4) begin
      chk("src2 header latency", 32'(obs_t[0] - start_cyc), 32'd3);
      chk("src2 back-to-back", 32'(obs_t[3] - obs_t[0]), 32'd3);
    end
    compare("src2 pkt0");
    add_pkt(2, 1, 1);
    drive();
    exp_q.push_back(hw(2, 0, 1));
    exp_words(2, 1, 0, 0);
    run_until("src2 pkt1", 50);
    compare("src2 pkt1");
    chk("grant_id holds", 32'(grant_id), 32'd2);
    chk("busy after burst", 32'(busy), 32'd0);

    // All sources requesting: strict round-robin order.
    do_reset();
    for (int s = 0; s < NSRC; s++) begin
      add_pkt(s, 0, 2);
      add_pkt(s, 1, 2);
    end
    drive();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSRC; s++) begin
        exp_q.push_back(hw(s, 0, r));
        exp_words(s, r, 0, 1);
      end
    end
    run_until("round robin", 200);
    compare("round robin");

    // Long packet split at MAX_BURST, interleaved with another source.
    add_pkt(1, 0, 40);
    add_pkt(3, 0, 2);
    add_pkt(3, 1, 2);
    drive();
    exp_q.push_back(hw(1, 0, 2));
    exp_words(1, 0, 0, 15);
    exp_q.push_back(hw(3, 0, 2));
    exp_words(3, 0, 0, 1);
    exp_q.push_back(hw(1, 1, 3));
    exp_words(1, 0, 16, 31);
    exp_q.push_back(hw(3, 0, 3));
    exp_words(3, 1, 0, 1);
    exp_q.push_back(hw(1, 1, 4));
    exp_words(1, 0, 32, 39);
    run_until("max burst", 300);
    compare("max burst");
    add_pkt(1, 1, 1);
    drive();
    exp_q.push_back(hw(1, 0, 5));
    exp_words(1, 1, 0, 0);
    run_until("cont cleared", 50);
    compare("cont cleared");

    // Asynchronous reset during the second burst of a split packet.
    add_pkt(2, 2, 20);
    drive();
    n_words = 0;
    for (int c = 0; c < 100 && n_words < 20; c++) begin
      step();
      n_words = obs.size();
    end
    chk("mid-burst reached", 32'(n_words >= 20), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst i0_valid", 32'(i0_valid), 32'd0);
    chk("async rst i0_data", i0_data, 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst t_ready", 32'(t_ready), 32'd0);
    chk("async rst grant_id", 32'(grant_id), 32'd0);
    clear_all();
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    add_pkt(0, 0, 1);
    add_pkt(2, 3, 1);
    drive();
    exp_q.push_back(hw(0, 0, 0));
    exp_words(0, 0, 0, 0);
    exp_q.push_back(hw(2, 0, 0));
    exp_words(2, 3, 0, 0);
    run_until("after reset", 50);
    compare("after reset");

    // Random link back-pressure and source gaps, sequence number wrap.
    rnd_ready  = 1'b1;
    gap_mode   = 1'b1;
    stab_err   = 0;
    onehot_err = 0;
    for (int p = 0; p <= 256; p++) begin
      add_pkt(3, p, (p % 3) + 1);
      exp_q.push_back(hw(3, 0, p % 256));
      exp_words(3, p, 0, p % 3);
    end
    drive();
    run_until("backpressure", 20000);
    compare("backpressure");
    chk("output stable while stalled", 32'(stab_err), 32'd0);
    chk("t_ready one-hot in burst", 32'(onehot_err), 32'd0);
    rnd_ready = 1'b0;
    gap_mode  = 1'b0;
    drive();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
